cosim_output_checker: RTL and testbench
=======================================

# cosim_output_checker

Synthesizable N-channel golden-vs-netlist comparator that generalises the team's single-bench mismatch counting into a reusable, parametrised block. It samples paired output buses on a strobe, counts samples and mismatches, and captures the first failure (channel and cycle stamp). It sits beside the device under test in co-simulation benches and in on-FPGA self-check designs.

## Interface
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 4: number of compared channels (≥1).
- `CNT_W`, 16: width of the sample and mismatch counters.
- `STAMP_W`, 24: width of the cycle stamp.
- `SETTLE`, 10: cycles ignored after `start` before comparison begins (0 allowed).
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin/restart a check run.
- `stop`  in  1  end the run.
- `sample_en`  in  1  compare strobe.
- `golden`  in  CHANNELS*WIDTH  reference outputs; channel k = bits [k*WIDTH +: WIDTH].
- `netlist`  in  CHANNELS*WIDTH  outputs under test, same packing.
- `ch_mask`  in  CHANNELS  1 = channel participates.
- `busy`  out  1  high in SETTLE or RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  done, sample_cnt≠0, mismatch_cnt=0.
- `sample_cnt`  out  CNT_W  compared samples.
- `mismatch_cnt`  out  CNT_W  samples with ≥1 mismatching channel.
- `first_valid`  out  1  first-mismatch record captured.
- `first_ch`  out  max(1,$clog2(CHANNELS))  lowest mismatching channel index of first failing sample.
- `first_stamp`  out  STAMP_W  stamp value at first failing sample.

## Operation
- FSM states: IDLE, SETTLE, RUN, DONE.
- IDLE: `start` → SETTLE (or RUN directly if SETTLE=0); clears counters, `first_*`, and stamp. `stop` ignored.
- SETTLE: settle counter counts to SETTLE−1, then → RUN. Samples ignored. `stop` → DONE. `start` ignored.
- RUN: on `sample_en`, compare every channel with `ch_mask[k]=1`; bitwise inequality = mismatch. `sample_cnt`+1; if any masked channel mismatches, `mismatch_cnt`+1 (once per sample, not per channel). `stop` → DONE; a sample on the same edge is still counted. `start` ignored.
- DONE: counters frozen. `start` → clears, SETTLE (restart). `stop` ignored.
- First capture: on the first counted mismatching sample of a run, latch `first_ch` (lowest index) and `first_stamp`, set `first_valid`; later mismatches do not overwrite.
- Stamp: increments each cycle in SETTLE and RUN, 0 on start; saturates at all-ones.
- Counters saturate at all-ones; never wrap.
- `ch_mask` = 0: samples are counted, mismatches never.
- Reset: asserting `rst` at any time, mid-run included, returns to IDLE immediately.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, all counters 0, `first_valid`=0, `first_ch`=0, `first_stamp`=0.
- All outputs registered. Effect of an edge-sampled input is visible after that edge (1-cycle latency).
- `start` in IDLE at edge t: `busy`=1 after t. First comparable sample at edge t+SETTLE+1.
- `stop` in RUN at edge t: `done`=1 and `pass` valid after t.
- `first_stamp` = cycles from the start edge to the sample edge, minus 1 (first SETTLE cycle = 0).

## Configuration
- `CHECKER_PER_CH_CNT_EN` defined: adds output `ch_mismatch_cnt` [CHANNELS*CNT_W]. Each channel has a saturating counter, incremented whenever that masked channel mismatches in RUN. Counters are cleared on start/reset.
- Undefined: port and counters absent. All other behaviour is identical.

## Test plan
- Matched run: CHANNELS=4, SETTLE=10. Start, 100 samples with identical buses, stop → sample_cnt=100, mismatch_cnt=0, pass=1, first_valid=0.
- Settle masking: golden≠netlist only during the 10 settle cycles, then 20 equal samples → mismatch_cnt=0, sample_cnt=20.
- First capture: ch2 and ch3 differ on the 5th RUN sample, ch0 differs on the 9th → mismatch_cnt=2, first_ch=2, first_stamp=SETTLE+4 (continuous sample_en), pass=0.
- Mask: ch1 always differs, ch_mask=4'b1101 → mismatch_cnt=0; with ch_mask=4'b1111 → mismatch_cnt=sample_cnt.
- Saturation/restart: CNT_W=4, 20 mismatching samples → mismatch_cnt=15. Start in DONE → counters 0, busy=1.
- Reset mid-RUN: rst low for 1 cycle after 30 samples → IDLE, all outputs 0. Stop then ignored; start proceeds normally.

Source files
------------

// File: rtl/cosim_output_checker.sv
`default_nettype none
// ============================================================================
// Module      : cosim_output_checker
// Description : N-channel golden-vs-netlist comparator. It counts strobed
//               samples and mismatching samples, and captures the channel and
//               cycle stamp of the first failure. Defining
//               CHECKER_PER_CH_CNT_EN adds the per-channel mismatch counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cosim_output_checker #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int STAMP_W  = 24,
    parameter int SETTLE   = 10,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        sample_en,
    input  logic [CHANNELS*WIDTH-1:0]   golden,
    input  logic [CHANNELS*WIDTH-1:0]   netlist,
    input  logic [CHANNELS-1:0]         ch_mask,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic [CNT_W-1:0]            mismatch_cnt,
    output logic                        first_valid,
    output logic [CH_W-1:0]             first_ch,
    output logic [STAMP_W-1:0]          first_stamp
`ifdef CHECKER_PER_CH_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0]   ch_mismatch_cnt
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int              SC_W          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] c_settle_last = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    logic [1:0]         state_q, state_d;
    logic [SC_W-1:0]    settle_q, settle_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic               first_valid_q, first_valid_d;
    logic [CH_W-1:0]    first_ch_q, first_ch_d;
    logic [STAMP_W-1:0] first_stamp_q, first_stamp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [CHANNELS-1:0] ch_mis;
    logic [CH_W-1:0]     lowest_ch;
    logic                restart;
    logic                count_sample;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_cmp
            assign ch_mis[k] = ch_mask[k] &&
                               (golden[k*WIDTH +: WIDTH] != netlist[k*WIDTH +: WIDTH]);
        end
    endgenerate

    // Descending scan so the lowest mismatching index wins.
    always_comb begin
        lowest_ch = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ch_mis[k]) lowest_ch = CH_W'(k);
        end
    end

    assign restart      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign count_sample = (state_q == ST_RUN) && sample_en;

    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        stamp_d        = stamp_q;
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        first_valid_d  = first_valid_q;
        first_ch_d     = first_ch_q;
        first_stamp_d  = first_stamp_q;

        if (restart) begin
            state_d        = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            settle_d       = '0;
            stamp_d        = '0;
            sample_cnt_d   = '0;
            mismatch_cnt_d = '0;
            first_valid_d  = 1'b0;
            first_ch_d     = '0;
            first_stamp_d  = '0;
        end else if ((state_q == ST_SETTLE) || (state_q == ST_RUN)) begin
            if (stamp_q != '1) stamp_d = stamp_q + STAMP_W'(1);
            if (state_q == ST_SETTLE) begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (settle_q == c_settle_last) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SC_W'(1);
                end
            end else begin
                // A sample on the stop edge is still counted.
                if (count_sample) begin
                    if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (|ch_mis) begin
                        if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                        if (!first_valid_q) begin
                            first_valid_d = 1'b1;
                            first_ch_d    = lowest_ch;
                            first_stamp_d = stamp_q;
                        end
                    end
                end
                if (stop) state_d = ST_DONE;
            end
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (sample_cnt_d != '0) && (mismatch_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            settle_q       <= '0;
            stamp_q        <= '0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            first_valid_q  <= 1'b0;
            first_ch_q     <= '0;
            first_stamp_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            stamp_q        <= stamp_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            first_valid_q  <= first_valid_d;
            first_ch_q     <= first_ch_d;
            first_stamp_q  <= first_stamp_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign sample_cnt   = sample_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign first_valid  = first_valid_q;
    assign first_ch     = first_ch_q;
    assign first_stamp  = first_stamp_q;

`ifdef CHECKER_PER_CH_CNT_EN
    logic [CNT_W-1:0] ch_cnt_q [CHANNELS];
    logic [CNT_W-1:0] ch_cnt_d [CHANNELS];

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            ch_cnt_d[k] = ch_cnt_q[k];
            if (restart) begin
                ch_cnt_d[k] = '0;
            end else if (count_sample && ch_mis[k] && (ch_cnt_q[k] != '1)) begin
                ch_cnt_d[k] = ch_cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CHANNELS; k++) ch_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) ch_cnt_q[k] <= ch_cnt_d[k];
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
            assign ch_mismatch_cnt[k*CNT_W +: CNT_W] = ch_cnt_q[k];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cosim_output_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cosim_output_checker
// Description : Scoreboard bench for cosim_output_checker with a run-level
//               reference model and a done-triggered monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cosim_output_checker;

    localparam int WIDTH    = 2;
    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int STAMP_W  = 24;
    localparam int SETTLE   = 10;
    localparam int BUS      = WIDTH * CHANNELS;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, stop, sample_en;
    logic [BUS-1:0]     golden, netlist;
    logic [CHANNELS-1:0] ch_mask;
    logic               busy, done, pass, first_valid;
    logic [CNT_W-1:0]   sample_cnt, mismatch_cnt;
    logic [1:0]         first_ch;
    logic [STAMP_W-1:0] first_stamp;
`ifdef CHECKER_PER_CH_CNT_EN
    logic [CHANNELS*CNT_W-1:0] ch_mismatch_cnt;
`endif

    typedef struct {
        int cnt;
        int mis;
        bit pas;
        bit fv;
        int fch;
        int fst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    cosim_output_checker #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W),
        .STAMP_W(STAMP_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .golden(golden), .netlist(netlist), .ch_mask(ch_mask),
        .busy(busy), .done(done), .pass(pass),
        .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
        .first_valid(first_valid), .first_ch(first_ch), .first_stamp(first_stamp)
`ifdef CHECKER_PER_CH_CNT_EN
        , .ch_mismatch_cnt(ch_mismatch_cnt)
`endif
    );

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising done presents one run result to the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1, required no completed run");
            end else begin
                e = exp_q.pop_front();
                chk("sample_cnt",   sample_cnt,   e.cnt);
                chk("mismatch_cnt", mismatch_cnt, e.mis);
                chk("pass",         pass,         e.pas);
                chk("first_valid",  first_valid,  e.fv);
                if (e.fv) begin
                    chk("first_ch",    first_ch,    e.fch);
                    chk("first_stamp", first_stamp, e.fst);
                end
            end
        end
        done_prev <= done;
    end

    // Reference model of one strobed RUN sample.
    function automatic void model_sample(inout exp_t e, input logic [BUS-1:0] g,
                                         input logic [BUS-1:0] n, input int stamp);
        int low;
        low = -1;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (ch_mask[c] && (g[c*WIDTH +: WIDTH] != n[c*WIDTH +: WIDTH])) low = c;
        end
        if (e.cnt < MAXC) e.cnt++;
        if (low >= 0) begin
            if (e.mis < MAXC) e.mis++;
            if (!e.fv) begin
                e.fv  = 1'b1;
                e.fch = low;
                e.fst = stamp;
            end
        end
    endfunction

    task automatic gen(input int kind, input int r, output logic [BUS-1:0] g,
                       output logic [BUS-1:0] n, output logic se);
        logic [BUS-1:0] flip;
        g  = BUS'($urandom);
        n  = g;
        se = 1'b1;
        case (kind)
            1: begin
                se = 1'($urandom);
                if ($urandom_range(0, 2) == 0) n = g ^ BUS'($urandom);
            end
            2: begin
                flip = 8'b0101_0000;
                if (r == 4) n = g ^ flip;
                flip = 8'b0000_0001;
                if (r == 8) n = g ^ flip;
            end
            3: begin
                flip = 8'b0000_0100;
                n = g ^ flip;
            end
            4: n = ~g;
            default: n = g;
        endcase
    endtask

    task automatic wait_drain;
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 8) begin
            tick;
            i++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL done_timeout: got done=%0d, required done=1 within 8 cycles", done);
            exp_q.delete();
        end
    endtask

    task automatic do_run(input int run_cycles, input int kind, input bit stop_in_settle);
        exp_t e;
        logic [BUS-1:0] g, n;
        logic se;
        int stop_k;
        e.cnt = 0; e.mis = 0; e.pas = 1'b0; e.fv = 1'b0; e.fch = 0; e.fst = 0;
        stop_k = stop_in_settle ? int'($urandom_range(1, SETTLE)) : 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        // Settle cycles carry random differences and strobes that must be ignored.
        for (int k = 1; k <= SETTLE; k++) begin
            golden    = BUS'($urandom);
            netlist   = BUS'($urandom);
            sample_en = 1'($urandom);
            stop      = (k == stop_k);
            tick;
            stop = 1'b0;
            if (k == stop_k) begin
                exp_q.push_back(e);
                wait_drain();
                return;
            end
        end
        for (int r = 0; r < run_cycles; r++) begin
            gen(kind, r, g, n, se);
            golden    = g;
            netlist   = n;
            sample_en = se;
            start     = (kind == 1) && ($urandom_range(0, 7) == 0);
            stop      = (r == run_cycles - 1);
            if (se) model_sample(e, g, n, SETTLE + r);
            tick;
        end
        start = 1'b0; stop = 1'b0; sample_en = 1'b0;
        e.pas = (e.cnt != 0) && (e.mis == 0);
        exp_q.push_back(e);
        wait_drain();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},         busy,         0);
        chk({tag, "_done"},         done,         0);
        chk({tag, "_pass"},         pass,         0);
        chk({tag, "_sample_cnt"},   sample_cnt,   0);
        chk({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
        chk({tag, "_first_valid"},  first_valid,  0);
        chk({tag, "_first_ch"},     first_ch,     0);
        chk({tag, "_first_stamp"},  first_stamp,  0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
        golden = '0; netlist = '0; ch_mask = 4'hF;
        tick;
        tick;
        check_zero("reset");
        rst = 1'b1;
        tick;

        do_run(100, 0, 1'b0);
        do_run(20, 0, 1'b0);
        do_run(12, 2, 1'b0);
        ch_mask = 4'b1101;
        do_run(25, 3, 1'b0);
        ch_mask = 4'b1111;
        do_run(25, 3, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ch_mask = 4'($urandom);
            do_run(int'($urandom_range(1, 40)), 1, ($urandom_range(0, 4) == 0));
        end

        ch_mask = 4'hF;
        do_run(300, 4, 1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_sample_cnt",   sample_cnt,   0);
        chk("restart_mismatch_cnt", mismatch_cnt, 0);
        chk("restart_busy",         busy,         1);
        chk("restart_done",         done,         0);
        chk("restart_first_valid",  first_valid,  0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick;

        // Reset in the middle of a failing run.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < SETTLE + 30; k++) begin
            golden    = BUS'($urandom);
            netlist   = ~golden;
            sample_en = 1'b1;
            tick;
        end
        sample_en = 1'b0;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #2;
        check_zero("midrun_reset");
        tick;
        rst  = 1'b1;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        tick;
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_done", done, 0);
        do_run(15, 1, 1'b0);

        repeat (3) tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
